// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: captures the ALU stage outputs, resolves PcSrc from the
// zero flag, and keeps a saturating count of taken branches.
module ex_mem_latch #(
  parameter int NBITS = 32,
  parameter int RBITS = 5,
  parameter int CBITS = 16
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Stall,
  input  logic             i_Flush,
  input  logic             i_Valid,
  input  logic [NBITS-1:0] i_AluResult,
  input  logic             i_Cero,
  input  logic [NBITS-1:0] i_RegB,
  input  logic [NBITS-1:0] i_PcBranch,
  input  logic [RBITS-1:0] i_WriteReg,
  input  logic             i_RegWrite,
  input  logic             i_MemRead,
  input  logic             i_MemWrite,
  input  logic             i_MemToReg,
  input  logic             i_Branch,
  input  logic             i_BranchNE,
  output logic             o_Valid,
  output logic [NBITS-1:0] o_AluResult,
  output logic [NBITS-1:0] o_RegB,
  output logic [NBITS-1:0] o_PcBranch,
  output logic [RBITS-1:0] o_WriteReg,
  output logic             o_RegWrite,
  output logic             o_MemRead,
  output logic             o_MemWrite,
  output logic             o_MemToReg,
  output logic             o_PcSrc,
  output logic [CBITS-1:0] o_BranchCount
);

  logic pc_src_next;
  logic reg_write_next;
  logic count_full;

  assign pc_src_next    = i_Valid & ((i_Branch & i_Cero) | (i_BranchNE & ~i_Cero));
  // Writes to register $zero are dropped here so WB never has to check for them.
  assign reg_write_next = i_Valid & i_RegWrite & (i_WriteReg != '0);
  assign count_full     = (o_BranchCount == {CBITS{1'b1}});

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      o_Valid       <= 1'b0;
      o_AluResult   <= '0;
      o_RegB        <= '0;
      o_PcBranch    <= '0;
      o_WriteReg    <= '0;
      o_RegWrite    <= 1'b0;
      o_MemRead     <= 1'b0;
      o_MemWrite    <= 1'b0;
      o_MemToReg    <= 1'b0;
      o_PcSrc       <= 1'b0;
      o_BranchCount <= '0;
    end else if (i_Flush) begin
      o_Valid     <= 1'b0;
      o_AluResult <= '0;
      o_RegB      <= '0;
      o_PcBranch  <= '0;
      o_WriteReg  <= '0;
      o_RegWrite  <= 1'b0;
      o_MemRead   <= 1'b0;
      o_MemWrite  <= 1'b0;
      o_MemToReg  <= 1'b0;
      o_PcSrc     <= 1'b0;
    end else if (!i_Stall) begin
      o_Valid     <= i_Valid;
      o_AluResult <= i_AluResult;
      o_RegB      <= i_RegB;
      o_PcBranch  <= i_PcBranch;
      o_WriteReg  <= i_WriteReg;
      o_RegWrite  <= reg_write_next;
      o_MemRead   <= i_Valid & i_MemRead;
      o_MemWrite  <= i_Valid & i_MemWrite;
      o_MemToReg  <= i_Valid & i_MemToReg;
      o_PcSrc     <= pc_src_next;
      if (pc_src_next && !count_full)
        o_BranchCount <= o_BranchCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed bench for ex_mem_latch; a second instance with a 4-bit counter covers saturation.
module tb_ex_mem_latch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, valid, cero;
  logic [31:0] alu, regb, pcb;
  logic [4:0]  wreg;
  logic        regwrite, memread, memwrite, memtoreg, branch, branchne;

  logic        o_valid, o_regwrite, o_memread, o_memwrite, o_memtoreg, o_pcsrc;
  logic [31:0] o_alu, o_regb, o_pcb;
  logic [4:0]  o_wreg;
  logic [15:0] o_count;

  logic        s_valid, s_regwrite, s_memread, s_memwrite, s_memtoreg, s_pcsrc;
  logic [31:0] s_alu, s_regb, s_pcb;
  logic [4:0]  s_wreg;
  logic [3:0]  s_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_mem_latch #(.NBITS(32), .RBITS(5), .CBITS(16)) dut (
    .i_Clk(clk), .i_Reset(rst_n), .i_Stall(stall), .i_Flush(flush), .i_Valid(valid),
    .i_AluResult(alu), .i_Cero(cero), .i_RegB(regb), .i_PcBranch(pcb), .i_WriteReg(wreg),
    .i_RegWrite(regwrite), .i_MemRead(memread), .i_MemWrite(memwrite), .i_MemToReg(memtoreg),
    .i_Branch(branch), .i_BranchNE(branchne),
    .o_Valid(o_valid), .o_AluResult(o_alu), .o_RegB(o_regb), .o_PcBranch(o_pcb),
    .o_WriteReg(o_wreg), .o_RegWrite(o_regwrite), .o_MemRead(o_memread),
    .o_MemWrite(o_memwrite), .o_MemToReg(o_memtoreg), .o_PcSrc(o_pcsrc),
    .o_BranchCount(o_count)
  );

  ex_mem_latch #(.NBITS(32), .RBITS(5), .CBITS(4)) sat (
    .i_Clk(clk), .i_Reset(rst_n), .i_Stall(stall), .i_Flush(flush), .i_Valid(valid),
    .i_AluResult(alu), .i_Cero(cero), .i_RegB(regb), .i_PcBranch(pcb), .i_WriteReg(wreg),
    .i_RegWrite(regwrite), .i_MemRead(memread), .i_MemWrite(memwrite), .i_MemToReg(memtoreg),
    .i_Branch(branch), .i_BranchNE(branchne),
    .o_Valid(s_valid), .o_AluResult(s_alu), .o_RegB(s_regb), .o_PcBranch(s_pcb),
    .o_WriteReg(s_wreg), .o_RegWrite(s_regwrite), .o_MemRead(s_memread),
    .o_MemWrite(s_memwrite), .o_MemToReg(s_memtoreg), .o_PcSrc(s_pcsrc),
    .o_BranchCount(s_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] ctl();
    return {o_valid, o_regwrite, o_memread, o_memwrite, o_memtoreg, o_pcsrc, 1'b0};
  endfunction

  task automatic set_all(input logic v);
    valid = v; cero = v; regwrite = v; memread = v; memwrite = v; memtoreg = v;
    branch = v; branchne = v;
    alu = v ? 32'h1111_2222 : 32'h0;
    regb = v ? 32'h3333_4444 : 32'h0;
    pcb = v ? 32'h5555_6666 : 32'h0;
    wreg = v ? 5'd7 : 5'd0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_all(1'b0);
    tick(); tick();
    chk("reset_ctl", {25'd0, ctl()}, 32'h0);
    chk("reset_alu", o_alu, 32'h0);
    chk("reset_cnt", {16'd0, o_count}, 32'h0);
    #3 rst_n = 1'b1;

    // Plain capture
    valid = 1'b1; alu = 32'h0000_0010; wreg = 5'd5; regwrite = 1'b1; memtoreg = 1'b0;
    regb = 32'hCAFE_0001; pcb = 32'h0000_0400;
    tick();
    chk("cap_alu", o_alu, 32'h10);
    chk("cap_wreg", {27'd0, o_wreg}, 32'd5);
    chk("cap_regb", o_regb, 32'hCAFE_0001);
    chk("cap_pcb", o_pcb, 32'h400);
    chk("cap_ctl", {25'd0, ctl()}, 32'b1100000_0 >> 1);

    // Async reset between edges, while stalled, with all inputs non-zero
    set_all(1'b1);
    tick();
    chk("pre_rst_alu", o_alu, 32'h1111_2222);
    chk("pre_rst_cnt", {16'd0, o_count}, 32'd1);
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", {25'd0, ctl()}, 32'h0);
    chk("async_rst_data", o_alu | o_regb | o_pcb | {27'd0, o_wreg}, 32'h0);
    chk("async_rst_cnt", {16'd0, o_count}, 32'h0);
    #2 rst_n = 1'b1;
    stall = 1'b0;
    tick();
    chk("post_rst_alu", o_alu, 32'h1111_2222);
    chk("post_rst_cnt", {16'd0, o_count}, 32'd1);

    // Branch decisions
    rst_n = 1'b0; #1 rst_n = 1'b1;
    set_all(1'b0);
    valid = 1'b1; branch = 1'b1; cero = 1'b1;
    tick();
    chk("beq_taken", {31'd0, o_pcsrc}, 32'd1);
    chk("beq_cnt", {16'd0, o_count}, 32'd1);
    branch = 1'b0; branchne = 1'b1; cero = 1'b1;
    tick();
    chk("bne_not_taken", {31'd0, o_pcsrc}, 32'd0);
    chk("bne_nt_cnt", {16'd0, o_count}, 32'd1);
    cero = 1'b0;
    tick();
    chk("bne_taken", {31'd0, o_pcsrc}, 32'd1);
    chk("bne_cnt", {16'd0, o_count}, 32'd2);
    branch = 1'b1; branchne = 1'b1; cero = 1'b1;
    tick();
    chk("both_taken", {31'd0, o_pcsrc}, 32'd1);
    chk("both_cnt", {16'd0, o_count}, 32'd3);

    // Stall holds everything, flush wins over stall
    branch = 1'b0; branchne = 1'b0;
    alu = 32'hDEAD_BEEF; wreg = 5'd9; regwrite = 1'b1; memread = 1'b1;
    tick();
    chk("st_cap_alu", o_alu, 32'hDEAD_BEEF);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu = 32'h1000 + i; wreg = 5'd3; branch = 1'b1; cero = 1'b1; memread = 1'b0;
      tick();
    end
    chk("stall_alu", o_alu, 32'hDEAD_BEEF);
    chk("stall_wreg", {27'd0, o_wreg}, 32'd9);
    chk("stall_ctl", {25'd0, ctl()}, 32'b1110000_0 >> 1);
    chk("stall_cnt", {16'd0, o_count}, 32'd3);
    flush = 1'b1;
    tick();
    chk("flush_ctl", {25'd0, ctl()}, 32'h0);
    chk("flush_alu", o_alu, 32'h0);
    chk("flush_wreg", {27'd0, o_wreg}, 32'h0);
    chk("flush_cnt", {16'd0, o_count}, 32'd3);
    flush = 1'b0; stall = 1'b0;

    // Bubble and $zero suppression
    set_all(1'b0);
    valid = 1'b0; memwrite = 1'b1; branch = 1'b1; cero = 1'b1; alu = 32'h0000_0ABC;
    tick();
    chk("bubble_ctl", {25'd0, ctl()}, 32'h0);
    chk("bubble_alu", o_alu, 32'h0ABC);
    chk("bubble_cnt", {16'd0, o_count}, 32'd3);
    valid = 1'b1; regwrite = 1'b1; wreg = 5'd0; branch = 1'b0; memread = 1'b1; memwrite = 1'b1;
    tick();
    chk("zero_reg_ctl", {25'd0, ctl()}, 32'b1011000_0 >> 1);

    // Saturation of the 4-bit counter; 16-bit counter keeps counting
    rst_n = 1'b0; #1 rst_n = 1'b1;
    set_all(1'b0);
    valid = 1'b1; branch = 1'b1; cero = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 14) chk("sat_14", {28'd0, s_count}, 32'hE);
      if (i == 15) chk("sat_15", {28'd0, s_count}, 32'hF);
    end
    chk("sat_17", {28'd0, s_count}, 32'hF);
    chk("wide_17", {16'd0, o_count}, 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
